mem_rr_arb4: RTL and testbench
==============================

Name: mem_rr_arb4

Overview:
- N-way round-robin arbiter for the shared data-side memory/Wishbone master port.
- Sits between the core-side requesters (dcache, MMU walker, debug, DMA) and the single downstream memory port.
- Latches one-cycle request pulses until served and muxes address, data and controls to the winner.
- Routes ack, read data and exception back to the winner only; a bus watchdog converts a hung transfer into an exception.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 255, cycles in ACTIVE without ack/exception before the watchdog fires.
- CNT_W, 8, watchdog counter width; TIMEOUT must be < 2**CNT_W.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- mem_req  out  1  downstream request strobe
- mem_we  out  1  downstream write enable
- mem_ack  in  1  downstream transfer complete
- mem_addr  out  `WB_ADDR_W  downstream address
- mem_o_data  out  `RW  downstream write data
- mem_i_data  in  `RW  downstream read data
- mem_sel  out  2  byte select
- mem_cache_enable  out  1  cacheable attribute
- mem_exception  in  1  downstream bus error
- rq_req  in  N  per-port request pulse/level
- rq_we  in  N  per-port write enable
- rq_addr  in  N*`WB_ADDR_W  packed addresses; port k at [k*W +: W]
- rq_o_data  in  N*`RW  packed write data
- rq_sel  in  2*N  packed byte selects
- rq_cache_enable  in  N  per-port cache attribute
- rq_ack  out  N  per-port ack (one-hot or zero)
- rq_i_data  out  `RW  read data, shared; valid only with rq_ack
- rq_exception  out  N  per-port exception (one-hot or zero)
- busy  out  1  transfer in flight (state ACTIVE)

Behaviour:
- Reset, async: state IDLE, grant=0, last=N-1, pending=0, wdog=0. After reset all outputs are 0: mem_req=0, rq_ack=0, rq_exception=0, busy=0, and the mux selects port 0.
- req_v = rq_req | pending.
- pending[k] sets on rq_req[k] and clears only on the cycle port k wins arbitration. Requesters hold addr/data/we/sel stable from their request until their ack or exception.
- Round robin: the winner is the first set bit of req_v scanning last+1, last+2, ... modulo N.
- The lookahead winner is combinational. The mux select is: winner in IDLE when req_v≠0, otherwise the registered grant.
- IDLE:
  - mem_req = |req_v. mem_req is combinational, so it has 0-cycle latency.
  - If req_v≠0: grant←winner, last←winner, pending[winner]←0.
  - Same-cycle mem_ack or mem_exception: zero-wait completion, route it to the winner, stay IDLE.
  - Otherwise go to ACTIVE and set wdog←0.
- ACTIVE:
  - mem_req=0 and busy=1.
  - On mem_ack: rq_ack[grant]=1, rq_i_data=mem_i_data, go to IDLE.
  - On mem_exception: rq_exception[grant]=1, go to IDLE.
  - If mem_ack and mem_exception arrive together, the exception wins and ack is suppressed.
  - Otherwise wdog increments. When wdog==TIMEOUT, rq_exception[grant] pulses for 1 cycle and the state returns to IDLE. An ack arriving in that same cycle is ignored.
- Returning from ACTIVE to IDLE costs no bubble: the next grant can issue in the cycle after completion.
- Requests arriving during ACTIVE are only latched in pending. A new rq_req from the port currently granted is latched as a fresh request.
- Starvation bound: any pending port is granted within N transfers.
- rq_ack and rq_exception are combinational from mem_ack/mem_exception plus the registered grant.

Optional Feature:
- Macro: MEM_ARB_PRIO0_EN.
- Defined: port 0 has absolute priority and wins whenever req_v[0]=1. Among ports 1..N-1, round robin continues with last updated only by their grants. Port 0 grants do not move last.
- Undefined: pure round robin over all N ports as above.

Decomposition:
- Shared package/header (with config.v): state encoding IDLE=1'b0 and ACTIVE=1'b1, plus default localparams for N and TIMEOUT.
- One natural sub-module: rr_pick. Inputs: N-bit request vector and last index. Output: winner index plus a valid flag. Purely combinational, reusable by the instruction-side arbiter.

Test Plan:
- Single request: rq_req=4'b0100 pulse, mem_ack 3 cycles later. Expect mem_req high 1 cycle with mem_addr=port2 addr, then rq_ack=4'b0100 with rq_i_data=mem_i_data. busy high for 3 cycles.
- Fairness: all four ports request continuously with ack every cycle in ACTIVE. Grant order is 0,1,2,3,0,1… No port is skipped, and each grants within 4 transfers.
- Zero-wait: mem_ack in the same cycle as mem_req. Expect the ack routed to the winner, busy stays 0, and the next pending port starts the following cycle.
- Watchdog: TIMEOUT=8, no ack. Expect rq_exception[grant] pulse exactly 8 cycles after entry to ACTIVE, return to IDLE, and a late mem_ack produces no rq_ack.
- Simultaneous events: mem_ack and mem_exception together give exception only. A rq_req from the granted port during ACTIVE is served again later in order.
- Reset mid-transfer: assert i_rst while ACTIVE. All outputs go 0 immediately, pending clears, and the first post-reset request from ports 0 and 3 grants port 0 first.
- MEM_ARB_PRIO0_EN variant: ports 0 and 2 request continuously. Port 0 always wins. Once port 0 drops, ports 1..3 round-robin.

Source files
------------

// File: rtl/mem_rr_arb4_pkg.sv
// ============================================================================
// Module : mem_rr_arb4_pkg
// Brief  : Shared state encoding, default sizing and bus widths for the
//          data-side memory round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef WB_ADDR_W
`define WB_ADDR_W 32
`endif

`ifndef RW
`define RW 32
`endif

package mem_rr_arb4_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int C_DEF_N       = 4;
    localparam int C_DEF_TIMEOUT = 255;
    localparam int C_DEF_CNT_W   = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rr_arb4_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set request bit scanning
//          last+1, last+2, ... modulo N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mem_rr_arb4_pkg::*;
#(
    parameter int N     = C_DEF_N,
    parameter int IDX_W = idx_width(C_DEF_N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        w_idx    = '0;
        for (int off = N; off >= 1; off--) begin
            w_idx = IDX_W'((int'(last_i) + off) % N);
            if (req_i[w_idx]) begin
                winner_o = w_idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_rr_arb4.sv
// ============================================================================
// Module : mem_rr_arb4
// Brief  : N-way round-robin arbiter for the shared data-side memory port,
//          with request latching, result routing and a bus watchdog.
//          Optional macro MEM_ARB_PRIO0_EN gives port 0 absolute priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_rr_arb4
    import mem_rr_arb4_pkg::*;
#(
    parameter int N       = C_DEF_N,
    parameter int TIMEOUT = C_DEF_TIMEOUT,
    parameter int CNT_W   = C_DEF_CNT_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      mem_req,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic [`WB_ADDR_W-1:0]     mem_addr,
    output logic [`RW-1:0]            mem_o_data,
    input  logic [`RW-1:0]            mem_i_data,
    output logic [1:0]                mem_sel,
    output logic                      mem_cache_enable,
    input  logic                      mem_exception,
    input  logic [N-1:0]              rq_req,
    input  logic [N-1:0]              rq_we,
    input  logic [N*`WB_ADDR_W-1:0]   rq_addr,
    input  logic [N*`RW-1:0]          rq_o_data,
    input  logic [2*N-1:0]            rq_sel,
    input  logic [N-1:0]              rq_cache_enable,
    output logic [N-1:0]              rq_ack,
    output logic [`RW-1:0]            rq_i_data,
    output logic [N-1:0]              rq_exception,
    output logic                      busy
);

    localparam int IDX_W = idx_width(N);

    arb_state_t       state_q,   state_d;
    logic [IDX_W-1:0] grant_q,   grant_d;
    logic [IDX_W-1:0] last_q,    last_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] wdog_q,    wdog_d;

    logic [N-1:0]     w_req_v;
    logic [N-1:0]     w_pick_req;
    logic [IDX_W-1:0] w_rr_win;
    logic             w_rr_vld;
    logic [IDX_W-1:0] w_win;
    logic             w_win_vld;
    logic             w_move_last;
    logic [IDX_W-1:0] w_sel;
    logic             w_wdog_fire;

    assign w_req_v = rq_req | pending_q;

`ifdef MEM_ARB_PRIO0_EN
    // Port 0 bypasses the rotation; the picker only sees ports 1..N-1.
    always_comb begin
        w_pick_req    = w_req_v;
        w_pick_req[0] = 1'b0;
    end
    assign w_win       = w_req_v[0] ? '0 : w_rr_win;
    assign w_win_vld   = w_req_v[0] | w_rr_vld;
    assign w_move_last = ~w_req_v[0];
`else
    assign w_pick_req  = w_req_v;
    assign w_win       = w_rr_win;
    assign w_win_vld   = w_rr_vld;
    assign w_move_last = 1'b1;
`endif

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (w_pick_req),
        .last_i   (last_q),
        .winner_o (w_rr_win),
        .valid_o  (w_rr_vld)
    );

    assign w_sel       = ((state_q == IDLE) && w_win_vld) ? w_win : grant_q;
    assign w_wdog_fire = (wdog_q == CNT_W'(TIMEOUT));

    assign mem_addr         = rq_addr[int'(w_sel)*`WB_ADDR_W +: `WB_ADDR_W];
    assign mem_o_data       = rq_o_data[int'(w_sel)*`RW +: `RW];
    assign mem_sel          = rq_sel[int'(w_sel)*2 +: 2];
    assign mem_we           = rq_we[w_sel];
    assign mem_cache_enable = rq_cache_enable[w_sel];
    assign rq_i_data        = (|rq_ack) ? mem_i_data : '0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        pending_d    = pending_q | rq_req;
        wdog_d       = wdog_q;
        mem_req      = 1'b0;
        busy         = 1'b0;
        rq_ack       = '0;
        rq_exception = '0;

        case (state_q)
            IDLE: begin
                mem_req = w_win_vld;
                if (w_win_vld) begin
                    grant_d          = w_win;
                    pending_d[w_win] = 1'b0;
                    if (w_move_last) begin
                        last_d = w_win;
                    end
                    // Zero-wait completion is routed straight to the winner.
                    if (mem_exception) begin
                        rq_exception[w_win] = 1'b1;
                    end else if (mem_ack) begin
                        rq_ack[w_win] = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                        wdog_d  = '0;
                    end
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (mem_exception || w_wdog_fire) begin
                    rq_exception[grant_q] = 1'b1;
                    state_d               = IDLE;
                end else if (mem_ack) begin
                    rq_ack[grant_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(N - 1);
            pending_q <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            wdog_q    <= wdog_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arb4.sv
// ============================================================================
// Module : tb_mem_rr_arb4
// Brief  : Self-checking bench for mem_rr_arb4: directed scenarios followed by
//          random traffic, every cycle checked against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef WB_ADDR_W
`define WB_ADDR_W 32
`endif
`ifndef RW
`define RW 32
`endif

module tb_mem_rr_arb4;

    localparam int N  = 4;
    localparam int AW = `WB_ADDR_W;
    localparam int DW = `RW;
    localparam int TO = 8;
`ifdef MEM_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_req, mem_we, mem_ack, mem_cache_enable, mem_exception, busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_o_data, mem_i_data, rq_i_data;
    logic [1:0]      mem_sel;
    logic [N-1:0]    rq_req, rq_we, rq_cache_enable, rq_ack, rq_exception;
    logic [N*AW-1:0] rq_addr;
    logic [N*DW-1:0] rq_o_data;
    logic [2*N-1:0]  rq_sel;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [N-1:0] m_pend;
    int           m_last, m_grant, m_wdog;
    bit           m_act;

    always #5 clk = ~clk;

    mem_rr_arb4 #(.N(N), .TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_o_data(mem_o_data), .mem_i_data(mem_i_data),
        .mem_sel(mem_sel), .mem_cache_enable(mem_cache_enable),
        .mem_exception(mem_exception),
        .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_o_data(rq_o_data),
        .rq_sel(rq_sel), .rq_cache_enable(rq_cache_enable),
        .rq_ack(rq_ack), .rq_i_data(rq_i_data), .rq_exception(rq_exception),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting port after the last winner.
    function automatic int pick(input logic [N-1:0] v);
        if (PRIO && v[0]) return 0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (m_last + i) % N;
            if (!(PRIO && idx == 0) && v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic randomize_data();
        for (int k = 0; k < N; k++) begin
            rq_addr[k*AW +: AW]   = AW'($urandom);
            rq_o_data[k*DW +: DW] = DW'($urandom);
        end
        rq_we           = N'($urandom);
        rq_sel          = (2*N)'($urandom);
        rq_cache_enable = N'($urandom);
        mem_i_data      = DW'($urandom);
    endtask

    task automatic check_mux(input int p);
        chk("mem_addr",  64'(mem_addr),         64'(rq_addr[p*AW +: AW]));
        chk("mem_odata", 64'(mem_o_data),       64'(rq_o_data[p*DW +: DW]));
        chk("mem_sel",   64'(mem_sel),          64'(rq_sel[p*2 +: 2]));
        chk("mem_we",    64'(mem_we),           64'(rq_we[p]));
        chk("mem_ce",    64'(mem_cache_enable), 64'(rq_cache_enable[p]));
    endtask

    task automatic step(input logic [N-1:0] req, input logic ack, input logic exc);
        logic [N-1:0] v, e_ack, e_exc;
        int           w, sel;
        bit           e_req;
        @(negedge clk);
        rq_req = req; mem_ack = ack; mem_exception = exc;
        randomize_data();
        #1;
        v = m_pend | req; e_ack = '0; e_exc = '0; e_req = 1'b0; w = -1; sel = m_grant;
        if (!m_act) begin
            e_req = (v != 0);
            if (v != 0) begin
                w = pick(v); sel = w;
                if (exc) e_exc[w] = 1'b1;
                else if (ack) e_ack[w] = 1'b1;
            end
        end else begin
            if (exc || m_wdog == TO) e_exc[m_grant] = 1'b1;
            else if (ack) e_ack[m_grant] = 1'b1;
        end
        chk("mem_req", 64'(mem_req),      64'(e_req));
        chk("busy",    64'(busy),         64'(m_act));
        chk("rq_ack",  64'(rq_ack),       64'(e_ack));
        chk("rq_exc",  64'(rq_exception), 64'(e_exc));
        chk("rq_data", 64'(rq_i_data),    (e_ack != 0) ? 64'(mem_i_data) : 64'd0);
        check_mux(sel);
        m_pend = v;
        if (!m_act) begin
            if (w >= 0) begin
                m_pend[w] = 1'b0;
                m_grant   = w;
                if (!(PRIO && w == 0)) m_last = w;
                if (!(ack || exc)) begin m_act = 1'b1; m_wdog = 0; end
            end
        end else if (exc || ack || m_wdog == TO) begin
            m_act = 1'b0;
        end else begin
            m_wdog++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rq_req = '0; mem_ack = 1'b1; mem_exception = 1'b0;
        randomize_data();
        m_pend = '0; m_last = N - 1; m_grant = 0; m_wdog = 0; m_act = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req),      64'd0);
        chk("rst_ack",     64'(rq_ack),       64'd0);
        chk("rst_exc",     64'(rq_exception), 64'd0);
        chk("rst_busy",    64'(busy),         64'd0);
        check_mux(0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp_p;
        rst = 1'b1; rq_req = '0; mem_ack = 1'b0; mem_exception = 1'b0;
        randomize_data();
        do_reset();

        // Single request, ack three cycles later
        step(4'b0100, 0, 0);
        chk("single_req",  64'(mem_req),  64'd1);
        chk("single_addr", 64'(mem_addr), 64'(rq_addr[2*AW +: AW]));
        step(4'b0000, 0, 0); chk("single_busy1", 64'(busy), 64'd1);
        step(4'b0000, 0, 0); chk("single_busy2", 64'(busy), 64'd1);
        step(4'b0000, 1, 0);
        chk("single_ack",  64'(rq_ack),    64'b0100);
        chk("single_data", 64'(rq_i_data), 64'(mem_i_data));
        step(4'b0000, 0, 0); chk("single_idle", 64'(busy), 64'd0);

        // Fairness / priority with continuous requests
        do_reset();
`ifndef MEM_ARB_PRIO0_EN
        exp_p = 0;
        repeat (16) begin
            step(4'b1111, m_act, 0);
            if (mem_req) begin
                chk("fair_order", 64'(mem_addr), 64'(rq_addr[exp_p*AW +: AW]));
                exp_p = (exp_p + 1) % N;
            end
        end
`else
        repeat (8) begin
            step(4'b0101, m_act, 0);
            if (mem_req) chk("prio0_wins", 64'(mem_addr), 64'(rq_addr[0 +: AW]));
        end
        exp_p = 1;
        repeat (12) begin
            step(4'b1110, m_act, 0);
            if (mem_req) begin
                chk("prio_rr_order", 64'(mem_addr), 64'(rq_addr[exp_p*AW +: AW]));
                exp_p = (exp_p == N - 1) ? 1 : exp_p + 1;
            end
        end
`endif

        // Zero-wait completions back to back
        do_reset();
        step(4'b0011, 1, 0);
        chk("zw_ack0",  64'(rq_ack), 64'b0001);
        chk("zw_busy0", 64'(busy),   64'd0);
        step(4'b0000, 1, 0);
        chk("zw_ack1",  64'(rq_ack), 64'b0010);
        step(4'b0000, 0, 0);
        chk("zw_done",  64'(mem_req), 64'd0);

        // Watchdog fires on the ninth ACTIVE cycle; ack there is ignored
        step(4'b0010, 0, 0);
        for (int i = 0; i < TO; i++) begin
            step(4'b0000, 0, 0);
            chk("wd_quiet", 64'(rq_exception), 64'd0);
        end
        step(4'b0000, 1, 0);
        chk("wd_exc",    64'(rq_exception), 64'b0010);
        chk("wd_no_ack", 64'(rq_ack),       64'd0);
        step(4'b0000, 1, 0);
        chk("wd_late_ack", 64'(rq_ack), 64'd0);

        // Exception beats ack; re-request from granted port is served later
        step(4'b0001, 0, 0);
        step(4'b0000, 1, 1);
        chk("sim_exc",    64'(rq_exception), 64'b0001);
        chk("sim_no_ack", 64'(rq_ack),       64'd0);
        step(4'b0100, 0, 0);
        step(4'b1100, 0, 0);
        step(4'b0000, 1, 0); chk("rereq_a", 64'(rq_ack), 64'b0100);
        step(4'b0000, 1, 0); chk("rereq_b", 64'(rq_ack), 64'b1000);
        step(4'b0000, 1, 0); chk("rereq_c", 64'(rq_ack), 64'b0100);
        step(4'b0000, 0, 0); chk("rereq_idle", 64'(mem_req), 64'd0);

        // Reset during a transfer drops pending work
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        do_reset();
        step(4'b1001, 1, 0);
        chk("prst_first", 64'(rq_ack), 64'b0001);
        step(4'b0000, 1, 0);
        chk("prst_second", 64'(rq_ack), 64'b1000);
        step(4'b0000, 0, 0);
        chk("prst_clear", 64'(mem_req), 64'd0);

        // Random traffic
        repeat (3000) begin
            logic [N-1:0] r;
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 3) == 0);
            step(r, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
